// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory sequencer: load/store handshake, lane steering, load extension.
// Build option: define MEM_ALIGN_CHECK_EN to raise AdEL/AdES on misaligned accesses.
module mem_access_ctrl #(
  parameter int BUS_AW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_ld_type,
  input  logic [1:0]        req_st_type,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [3:0]        bus_byteen,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_exc,
  output logic [4:0]        resp_exc_code
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        exc_now;
  logic        busy;
  logic        st_p0;
  logic [2:0]  ld_type_p0;
  logic [1:0]  st_type_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] rdata_p1;
  logic        exc_p1;
  logic [4:0]  code_p1;

  function automatic logic [3:0] st_byteen(input logic [1:0] t, input logic [1:0] a);
    case (t)
      2'd1:    st_byteen = a[1] ? 4'b1100 : 4'b0011;
      2'd2:    st_byteen = 4'b0001 << a;
      default: st_byteen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [1:0] t, input logic [31:0] w);
    case (t)
      2'd1:    st_data = {2{w[15:0]}};
      2'd2:    st_data = {4{w[7:0]}};
      default: st_data = w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] t, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = d >> {a, 3'b000};
    b  = signed'(sh[7:0]);
    h  = signed'(a[1] ? d[31:16] : d[15:0]);
    case (t)
      3'd1:    load_ext = {24'd0, b};
      3'd2:    load_ext = 32'(b);
      3'd3:    load_ext = {16'd0, h};
      3'd4:    load_ext = 32'(h);
      default: load_ext = d;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic st, input logic [2:0] lt,
                                      input logic [1:0] stt, input logic [1:0] a);
    logic half, byte_acc;
    half     = st ? (stt == 2'd1) : (lt == 3'd3 || lt == 3'd4);
    byte_acc = st ? (stt == 2'd2) : (lt == 3'd1 || lt == 3'd2);
    if (byte_acc)  misaligned = 1'b0;
    else if (half) misaligned = a[0];
    else           misaligned = (a != 2'b00);
  endfunction

  assign exc_now = misaligned(req_store, req_ld_type, req_st_type, req_addr[1:0]);
`else
  assign exc_now = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign busy      = (state == BUS);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = exc_now ? RESP : BUS;
      BUS:     if (bus_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p0: request latched on accept, held for the whole bus access
  always_ff @(posedge clk) begin
    if (reset) begin
      st_p0      <= 1'b0;
      ld_type_p0 <= 3'd0;
      st_type_p0 <= 2'd0;
      addr_p0    <= 32'd0;
      wdata_p0   <= 32'd0;
    end else if (accept) begin
      st_p0      <= req_store;
      ld_type_p0 <= req_ld_type;
      st_type_p0 <= req_st_type;
      addr_p0    <= req_addr;
      wdata_p0   <= req_wdata;
    end
  end

  // Stage p1: response fields, updated only when a response is being produced
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= 32'd0;
      exc_p1   <= 1'b0;
      code_p1  <= 5'd0;
    end else if (accept && exc_now) begin
      rdata_p1 <= 32'd0;
      exc_p1   <= 1'b1;
      code_p1  <= req_store ? 5'd5 : 5'd4;
    end else if (busy && bus_ack) begin
      rdata_p1 <= st_p0 ? 32'd0 : load_ext(ld_type_p0, addr_p0[1:0], bus_rdata);
      exc_p1   <= 1'b0;
      code_p1  <= 5'd0;
    end
  end

  // Bus outputs are gated by state so they read as zero outside BUS
  assign bus_req       = busy;
  assign bus_we        = busy & st_p0;
  assign bus_addr      = busy ? {addr_p0[BUS_AW-1:2], 2'b00} : '0;
  assign bus_byteen    = (busy && st_p0) ? st_byteen(st_type_p0, addr_p0[1:0]) : 4'b0000;
  assign bus_wdata     = (busy && st_p0) ? st_data(st_type_p0, wdata_p0) : 32'd0;
  assign resp_valid    = (state == RESP);
  assign resp_rdata    = rdata_p1;
  assign resp_exc      = exc_p1;
  assign resp_exc_code = code_p1;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed plan cases plus randomized accesses
// against a size/lane arithmetic reference model.
module tb_mem_access_ctrl;
  localparam int BUS_AW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_ld_type;
  logic [1:0]        req_st_type;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              bus_req;
  logic              bus_we;
  logic [BUS_AW-1:0] bus_addr;
  logic [3:0]        bus_byteen;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_exc;
  logic [4:0]        resp_exc_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.BUS_AW(BUS_AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_ld_type(req_ld_type), .req_st_type(req_st_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .resp_exc_code(resp_exc_code)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes
  function automatic int acc_size(input bit st, input logic [2:0] ldt, input logic [1:0] stt);
    if (st) return (stt == 2'd1) ? 2 : (stt == 2'd2) ? 1 : 4;
    if (ldt == 3'd1 || ldt == 3'd2) return 1;
    if (ldt == 3'd3 || ldt == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_byteen(input int sz, input logic [31:0] a);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] w);
    if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_rdata(input int sz, input logic [2:0] ldt,
                                              input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (sz == 1) begin
      v = (r >> (8 * (a % 4))) & 32'hFF;
      if (ldt == 3'd2 && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    if (sz == 2) begin
      v = (r >> (8 * (a & 2))) & 32'hFFFF;
      if (ldt == 3'd4 && v >= 32'h8000) v = v - 32'h1_0000;
      return v;
    end
    return r;
  endfunction

  logic        nx_st;
  logic [2:0]  nx_ldt;
  logic [1:0]  nx_stt;
  logic [31:0] nx_addr, nx_wd;

  // One complete access; with hold set, the next request is presented (and must be
  // ignored) while this one is still in flight.
  task automatic access(input bit st, input logic [2:0] ldt, input logic [1:0] stt,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly, input bit hold);
    int sz;
    bit exc;
    sz = acc_size(st, ldt, stt);
`ifdef MEM_ALIGN_CHECK_EN
    exc = (addr % sz) != 0;
`else
    exc = 1'b0;
`endif
    check("ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_store = st; req_ld_type = ldt; req_st_type = stt;
    req_addr = addr; req_wdata = wd;
    tick();
    if (hold) begin
      req_store = nx_st; req_ld_type = nx_ldt; req_st_type = nx_stt;
      req_addr = nx_addr; req_wdata = nx_wd;
    end else begin
      req_valid = 1'b0;
    end
    if (exc) begin
      check("exc_resp_valid", resp_valid, 1);
      check("exc_flag", resp_exc, 1);
      check("exc_code", resp_exc_code, st ? 5 : 4);
      check("exc_no_bus_req", bus_req, 0);
      check("exc_rdata", resp_rdata, 0);
    end else begin
      for (int k = 0; k <= dly; k++) begin
        check("bus_req", bus_req, 1);
        check("bus_we", bus_we, st);
        check("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
        check("bus_byteen", bus_byteen, st ? model_byteen(sz, addr) : 4'h0);
        if (st) check("bus_wdata", bus_wdata, model_wdata(sz, wd));
        check("no_early_resp", resp_valid, 0);
        check("busy_not_ready", req_ready, 0);
        bus_ack   = (k == dly);
        bus_rdata = (k == dly) ? rd : $urandom;
        tick();
      end
      bus_ack = 1'b0;
      check("resp_valid", resp_valid, 1);
      check("resp_rdata", resp_rdata, st ? 32'd0 : model_rdata(sz, ldt, addr, rd));
      check("resp_exc_clear", resp_exc, 0);
      check("resp_code_clear", resp_exc_code, 0);
      check("resp_bus_idle", bus_req, 0);
    end
    check("resp_not_ready", req_ready, 0);
    tick();
    check("resp_one_cycle", resp_valid, 0);
    check("ready_after_resp", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_ld_type = 3'd0;
    req_st_type = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    nx_st = 1'b0; nx_ldt = 3'd0; nx_stt = 2'd0; nx_addr = 32'd0; nx_wd = 32'd0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_byteen", bus_byteen, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_exc", resp_exc, 0);
    check("rst_resp_code", resp_exc_code, 0);

    // Ack outside BUS must be ignored
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    check("idle_ack_no_resp", resp_valid, 0);
    check("idle_ack_ready", req_ready, 1);
    check("idle_ack_no_bus", bus_req, 0);
    bus_ack = 1'b0;

    // Directed plan cases
    access(1'b0, 3'd2, 2'd0, 32'h0000_1003, 32'd0, 32'h8012_3456, 0, 1'b0);
    check("sb_load_value", resp_rdata, 32'hFFFF_FF80);
    access(1'b1, 3'd0, 2'd1, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 3, 1'b0);
    access(1'b0, 3'd0, 2'd0, 32'h0000_3001, 32'd0, 32'h1357_9BDF, 1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    check("misaligned_word_code", resp_exc_code, 4);
`else
    check("misaligned_word_pass", resp_rdata, 32'h1357_9BDF);
`endif
    nx_st = 1'b1; nx_ldt = 3'd0; nx_stt = 2'd0; nx_addr = 32'h0000_4000; nx_wd = 32'hCAFE_F00D;
    access(1'b0, 3'd3, 2'd0, 32'h0000_0002, 32'd0, 32'h9ABC_1234, 2, 1'b1);
    check("uh_load_value", resp_rdata, 32'h0000_9ABC);
    access(nx_st, nx_ldt, nx_stt, nx_addr, nx_wd, 32'd0, 0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    access(1'b1, 3'd0, 2'd1, 32'h0000_5001, 32'h1234_5678, 32'd0, 0, 1'b0);
`endif

    // Reset while a byte store waits forever for its ack
    check("rst_case_ready", req_ready, 1);
    req_valid = 1'b1; req_store = 1'b1; req_st_type = 2'd2; req_ld_type = 3'd0;
    req_addr = 32'h0000_0011; req_wdata = 32'h0000_005A;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_bus_req", bus_req, 1);
      check("stall_byteen", bus_byteen, 4'b0010);
      check("stall_wdata", bus_wdata, 32'h5A5A_5A5A);
      check("stall_addr", bus_addr, 32'h0000_0010);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_bus_req", bus_req, 0);
    check("abort_ready", req_ready, 1);
    check("abort_no_resp", resp_valid, 0);
    check("abort_byteen", bus_byteen, 0);
    check("abort_addr", bus_addr, 0);
    check("abort_wdata", bus_wdata, 0);
    tick();
    check("abort_no_late_resp", resp_valid, 0);
    access(1'b0, 3'd1, 2'd0, 32'h0000_0021, 32'd0, 32'hA1B2_C3D4, 1, 1'b0);
    check("post_reset_load", resp_rdata, 32'h0000_00C3);

    // Randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
